uart_fifo: RTL and testbench

// - Buffered UART transmitter behind the APB UART slave. Bytes pushed by the bus side go into a synchronous FIFO.
// - A serial engine drains the FIFO and emits 8N1 frames on tx.
// - tx_fifo_full provides back-pressure to the bus (PREADY); busy reports any pending or in-flight traffic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_fifo_if.sv | 28 ++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_fifo.sv | 131 +++++++++++++
 tb/tb_uart_fifo.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the buffered UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // start + 8 data + stop
    localparam int FRAME_BITS           = 10;
    // 50 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_FIFO_DEPTH   = 16;
    localparam int DEFAULT_DATA_WIDTH   = 8;

endpackage

// File: rtl/uart_fifo_if.sv
// rtl/uart_fifo_if.sv - bus-side push port and serial/status outputs of the UART transmitter
interface uart_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();
    logic [DATA_WIDTH-1:0] tx_byte;       // byte to enqueue, sampled when transmit=1
    logic                  transmit;      // push strobe, one byte per cycle while high
    logic                  tx;            // serial line, idle high
    logic                  busy;          // FIFO non-empty or frame in progress
    logic                  tx_fifo_full;  // FIFO holds FIFO_DEPTH entries

    modport master (
        output tx_byte,
        output transmit,
        input  tx,
        input  busy,
        input  tx_fifo_full
    );

    modport slave (
        input  tx_byte,
        input  transmit,
        output tx,
        output busy,
        output tx_fifo_full
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock show-ahead FIFO buffering transmit bytes
// Ports: clk, rst (sync active-high); push/din write side; pop/dout read side
// (dout = head entry while !empty); full/empty derived from the registered count.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Acceptance uses the pre-edge flags, so a pop on a full FIFO does not
    // make room for a same-edge push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == COUNT_FULL);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset; contents are only visible once count says so.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - buffered 8N1 UART transmitter: FIFO plus serial engine
// Ports: clk, rst (sync active-high); bus (uart_fifo_if.slave) carries
// tx_byte/transmit in and tx/busy/tx_fifo_full out.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    uart_fifo_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;

    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.transmit),
        .pop   (fifo_pop),
        .din   (bus.tx_byte),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the level the line takes after the edge, so every bit
    // boundary lands exactly on a baud counter wrap and tx stays a flop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    shift_d  = fifo_dout;
                    fifo_pop = 1'b1;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end

            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.busy         = (state_q != IDLE) || !fifo_empty;
    assign bus.tx_fifo_full = fifo_full;

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - scoreboard testbench for uart_fifo with a timeline reference model
module tb_uart_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_fifo_if #(.DATA_WIDTH(8)) bus ();

    uart_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_WIDTH   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: bytes waiting in the FIFO, the edge at which the
    // engine last took a byte, and that byte. A frame occupies FRAME edges
    // and the engine can take the next byte one edge later.
    logic [7:0] mq [$];
    logic [7:0] sb_q [$];
    int         cyc      = 0;
    int         last_pop = -1000;
    logic [7:0] cur_byte = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic step(input logic r, input logic push, input logic [7:0] d);
        int   pre;
        int   dd;
        int   exp_tx;
        logic take;
        rst          = r;
        bus.transmit = push;
        bus.tx_byte  = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            mq.delete();
            sb_q.delete();
            last_pop = -1000;
        end else begin
            pre  = mq.size();
            take = (cyc - last_pop >= FRAME + 1) && (pre > 0);
            if (take) begin
                cur_byte = mq.pop_front();
                last_pop = cyc;
            end
            if (push && pre < DEPTH) begin
                mq.push_back(d);
                sb_q.push_back(d);
            end
        end
        #1;
        dd = cyc - last_pop;
        if (dd < CPB)          exp_tx = 0;
        else if (dd < 9 * CPB) exp_tx = int'(cur_byte[(dd - CPB) / CPB]);
        else                   exp_tx = 1;
        check("tx", int'(bus.tx), exp_tx);
        check("busy", int'(bus.busy), int'(mq.size() > 0 || dd < FRAME));
        check("full", int'(bus.tx_fifo_full), int'(mq.size() == DEPTH));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((mq.size() > 0 || cyc - last_pop < FRAME + 1) && guard < 2000) begin
            step(1'b0, 1'b0, 8'h00);
            guard++;
        end
        check("drain_timeout", int'(guard < 2000), 1);
        idle(3);
    endtask

    // Monitor: decodes frames off the line at mid-bit and compares each byte
    // with the head of the scoreboard queue. A reset during a frame abandons it.
    initial begin
        logic [7:0] b;
        logic       s;
        bit         abort;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && bus.tx === 1'b0) begin
                abort = 1'b0;
                b     = 8'h00;
                repeat (CPB / 2) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                end
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                    end
                    b[j] = bus.tx;
                end
                repeat (CPB) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                end
                s = bus.tx;
                if (!abort) begin
                    check("stop_bit", int'(s), 1);
                    if (sb_q.size() == 0) check("frame_queue_depth", sb_q.size(), 1);
                    else check("frame_byte", int'(b), int'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.transmit = 1'b0;
        bus.tx_byte  = 8'h00;

        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        idle(3);

        // single byte
        step(1'b0, 1'b1, 8'hA5);
        idle(45);

        // fill past capacity; 0x06 arrives while full
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i));
        drain();

        // back-to-back frames
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        drain();

        // push on the very edge the engine pops with one byte queued
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        while (cyc + 1 - last_pop < FRAME + 1) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h33);
        drain();

        // reset mid-DATA with two bytes queued
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h44);
        step(1'b0, 1'b1, 8'h55);
        idle(15);
        step(1'b1, 1'b0, 8'h00);
        idle(60);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'($urandom_range(0, 7) == 0), 8'($urandom));
        end
        drain();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
